// File: rtl/bp_me_burst_to_axil_pkg.sv
// Shared BedRock IO header and message definitions for the burst-to-AXIL bridge.
package bp_me_burst_to_axil_pkg;

    localparam int paddr_width_p   = 40;
    localparam int payload_width_p = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        bp_bedrock_mem_type_e       msg_type;
    } bp_bedrock_mem_header_s;

    // Cached and uncached flavours are handled identically on this path.
    function automatic logic is_read(bp_bedrock_mem_type_e t);
        return (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
    endfunction

    function automatic logic is_write(bp_bedrock_mem_type_e t);
        return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
    endfunction

endpackage

// File: rtl/bp_me_axil_lane_align.sv
// Byte-lane steering between a BedRock data beat and an AXI4-Lite data bus:
// write strobes, write-data replication and read-data shift/replication.
module bp_me_axil_lane_align #(
    parameter int io_data_width_p   = 64,
    parameter int axil_data_width_p = 32,
    localparam int axil_bytes_lp    = axil_data_width_p / 8,
    localparam int io_bytes_lp      = io_data_width_p / 8,
    localparam int lg_axil_bytes_lp = $clog2(axil_bytes_lp)
) (
    input  logic [lg_axil_bytes_lp-1:0]  off,
    input  logic [2:0]                   size,
    input  logic [io_data_width_p-1:0]   cmd_data,
    input  logic [axil_data_width_p-1:0] rdata,
    output logic [axil_bytes_lp-1:0]     strb,
    output logic [axil_data_width_p-1:0] wdata,
    output logic [io_data_width_p-1:0]  resp_data
);

    logic [axil_data_width_p-1:0] shifted;
    int nbytes;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        strb      = '0;
        wdata     = '0;
        resp_data = '0;
        nbytes    = 32'(1) << size;
        for (int i = 0; i < axil_bytes_lp; i++) begin
            strb[i]          = (i >= int'(off)) && (i < int'(off) + nbytes);
            wdata[8*i +: 8]  = cmd_data[8*(i & (nbytes-1)) +: 8];
        end
        // Masking with the bus width keeps the index in range even for illegal sizes.
        for (int j = 0; j < io_bytes_lp; j++)
            resp_data[8*j +: 8] = shifted[8*(j & (nbytes-1) & (axil_bytes_lp-1)) +: 8];
    end

endmodule

// File: rtl/bp_me_burst_to_axil.sv
// BedRock Burst IO command -> AXI4-Lite master bridge; one transaction in flight,
// one BedRock response per command, responses in command order.
module bp_me_burst_to_axil
    import bp_me_burst_to_axil_pkg::*;
#(
    parameter int io_data_width_p   = 64,
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int axil_bytes_lp    = axil_data_width_p / 8,
    localparam int lg_axil_bytes_lp = $clog2(axil_bytes_lp)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  bp_bedrock_mem_header_s       io_cmd_header_i,
    input  logic                         io_cmd_header_v_i,
    output logic                         io_cmd_header_ready_and_o,
    input  logic                         io_cmd_has_data_i,
    input  logic [io_data_width_p-1:0]   io_cmd_data_i,
    input  logic                         io_cmd_data_v_i,
    input  logic                         io_cmd_data_last_i,
    output logic                         io_cmd_data_ready_and_o,
    output bp_bedrock_mem_header_s       io_resp_header_o,
    output logic                         io_resp_header_v_o,
    input  logic                         io_resp_header_ready_and_i,
    output logic                         io_resp_has_data_o,
    output logic [io_data_width_p-1:0]   io_resp_data_o,
    output logic                         io_resp_data_v_o,
    output logic                         io_resp_data_last_o,
    input  logic                         io_resp_data_ready_and_i,
    output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
    output logic [2:0]                   m_axil_awprot_o,
    output logic                         m_axil_awvalid_o,
    input  logic                         m_axil_awready_i,
    output logic [axil_data_width_p-1:0] m_axil_wdata_o,
    output logic [axil_bytes_lp-1:0]     m_axil_wstrb_o,
    output logic                         m_axil_wvalid_o,
    input  logic                         m_axil_wready_i,
    input  logic [1:0]                   m_axil_bresp_i,
    input  logic                         m_axil_bvalid_i,
    output logic                         m_axil_bready_o,
    output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
    output logic [2:0]                   m_axil_arprot_o,
    output logic                         m_axil_arvalid_o,
    input  logic                         m_axil_arready_i,
    input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
    input  logic [1:0]                   m_axil_rresp_i,
    input  logic                         m_axil_rvalid_i,
    output logic                         m_axil_rready_o,
    output logic                         error_o
);

    typedef enum logic [2:0] {
        e_ready, e_cmd_data, e_write, e_bresp,
        e_read_addr, e_read_data, e_resp_hdr, e_resp_data
    } state_e;

    state_e                       state_r, state_n;
    bp_bedrock_mem_header_s       hdr_r;
    logic [io_data_width_p-1:0]   data_r;
    logic [axil_data_width_p-1:0] rdata_r;
    logic aw_sent_r, aw_sent_n, w_sent_r, w_sent_n;
    logic live_r;
    logic hdr_fire, data_fire, aw_done, w_done;
    logic unused;

    // live_r keeps the header port closed while reset is (or was just) asserted.
    assign io_cmd_header_ready_and_o = live_r && (state_r == e_ready);
    assign io_cmd_data_ready_and_o   = (state_r == e_cmd_data);
    assign hdr_fire  = io_cmd_header_ready_and_o && io_cmd_header_v_i;
    assign data_fire = io_cmd_data_ready_and_o && io_cmd_data_v_i;

    assign m_axil_awvalid_o = (state_r == e_write) && !aw_sent_r;
    assign m_axil_wvalid_o  = (state_r == e_write) && !w_sent_r;
    assign aw_done = aw_sent_r || (m_axil_awvalid_o && m_axil_awready_i);
    assign w_done  = w_sent_r  || (m_axil_wvalid_o && m_axil_wready_i);
    assign m_axil_bready_o  = (state_r == e_bresp);
    assign m_axil_arvalid_o = (state_r == e_read_addr);
    assign m_axil_rready_o  = (state_r == e_read_data);
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_awaddr_o  = {hdr_r.addr[axil_addr_width_p-1:lg_axil_bytes_lp], {lg_axil_bytes_lp{1'b0}}};
    assign m_axil_araddr_o  = m_axil_awaddr_o;

    assign io_resp_header_o    = hdr_r;
    assign io_resp_header_v_o  = (state_r == e_resp_hdr);
    assign io_resp_has_data_o  = io_resp_header_v_o && is_read(hdr_r.msg_type);
    assign io_resp_data_v_o    = (state_r == e_resp_data);
    assign io_resp_data_last_o = io_resp_data_v_o;

    assign error_o = (m_axil_bready_o && m_axil_bvalid_i && (m_axil_bresp_i != 2'b00))
                  || (m_axil_rready_o && m_axil_rvalid_i && (m_axil_rresp_i != 2'b00));

    assign unused = ^{io_cmd_has_data_i, io_cmd_data_last_i};

    bp_me_axil_lane_align #(
        .io_data_width_p  (io_data_width_p),
        .axil_data_width_p(axil_data_width_p)
    ) align (
        .off      (hdr_r.addr[lg_axil_bytes_lp-1:0]),
        .size     (hdr_r.size),
        .cmd_data (data_r),
        .rdata    (rdata_r),
        .strb     (m_axil_wstrb_o),
        .wdata    (m_axil_wdata_o),
        .resp_data(io_resp_data_o)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_ready;
            hdr_r     <= '0;
            data_r    <= '0;
            rdata_r   <= '0;
            aw_sent_r <= 1'b0;
            w_sent_r  <= 1'b0;
            live_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            aw_sent_r <= aw_sent_n;
            w_sent_r  <= w_sent_n;
            live_r    <= 1'b1;
            if (hdr_fire)  hdr_r  <= io_cmd_header_i;
            if (data_fire) data_r <= io_cmd_data_i;
            if (m_axil_rready_o && m_axil_rvalid_i) rdata_r <= m_axil_rdata_i;
        end
    end

    always_comb begin
        state_n   = state_r;
        aw_sent_n = aw_sent_r;
        w_sent_n  = w_sent_r;
        case (state_r)
            e_ready:     if (hdr_fire)
                             state_n = is_write(io_cmd_header_i.msg_type) ? e_cmd_data : e_read_addr;
            e_cmd_data:  if (data_fire) state_n = e_write;
            e_write: begin
                aw_sent_n = aw_done;
                w_sent_n  = w_done;
                if (aw_done && w_done) begin
                    state_n   = e_bresp;
                    aw_sent_n = 1'b0;
                    w_sent_n  = 1'b0;
                end
            end
            e_bresp:     if (m_axil_bvalid_i) state_n = e_resp_hdr;
            e_read_addr: if (m_axil_arready_i) state_n = e_read_data;
            e_read_data: if (m_axil_rvalid_i) state_n = e_resp_hdr;
            e_resp_hdr:  if (io_resp_header_ready_and_i)
                             state_n = is_read(hdr_r.msg_type) ? e_resp_data : e_ready;
            e_resp_data: if (io_resp_data_ready_and_i) state_n = e_ready;
            default:     state_n = e_ready;
        endcase
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        hdr_fire |-> (io_cmd_header_i.size <= 3'(lg_axil_bytes_lp))
                  && (is_read(io_cmd_header_i.msg_type) || is_write(io_cmd_header_i.msg_type)));
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        data_fire |-> io_cmd_data_last_i);

endmodule

// File: tb/tb_bp_me_burst_to_axil.sv
// Scoreboard bench: directed commands push expectations; a negedge monitor plays the
// AXIL subordinate and pops/compares on every DUT handshake.
module tb_bp_me_burst_to_axil;
    import bp_me_burst_to_axil_pkg::*;

    typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
    typedef struct { bp_bedrock_mem_header_s hdr; logic has_data; int lat; } resp_exp_t;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    bp_bedrock_mem_header_s cmd_hdr = '0, resp_hdr;
    logic cmd_hdr_v = 0, hdr_ready, cmd_has_data = 0, cmd_data_v = 0, cmd_last = 0, data_ready;
    logic [63:0] cmd_data = '0, resp_data;
    logic resp_hdr_v, resp_rdy = 1, resp_has_data, resp_data_v, resp_last, resp_data_rdy = 1;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
    logic arvalid, arready = 0, rvalid = 0, rready, error;
    logic [1:0] bresp = 0, rresp = 0;

    logic [31:0] aw_q[$], ar_q[$];
    w_exp_t      w_q[$];
    resp_exp_t   resp_q[$];
    logic [63:0] rd_q[$];

    int checks = 0, errors = 0;
    int w_stall_cfg = 0;
    logic [1:0]  b_resp_cfg = 0, r_resp_cfg = 0;
    logic [31:0] r_data_cfg = '0;

    bp_me_burst_to_axil dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .io_cmd_header_i(cmd_hdr), .io_cmd_header_v_i(cmd_hdr_v), .io_cmd_header_ready_and_o(hdr_ready),
        .io_cmd_has_data_i(cmd_has_data), .io_cmd_data_i(cmd_data), .io_cmd_data_v_i(cmd_data_v),
        .io_cmd_data_last_i(cmd_last), .io_cmd_data_ready_and_o(data_ready),
        .io_resp_header_o(resp_hdr), .io_resp_header_v_o(resp_hdr_v), .io_resp_header_ready_and_i(resp_rdy),
        .io_resp_has_data_o(resp_has_data), .io_resp_data_o(resp_data), .io_resp_data_v_o(resp_data_v),
        .io_resp_data_last_o(resp_last), .io_resp_data_ready_and_i(resp_data_rdy),
        .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
        .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
        .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
        .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
        .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready),
        .error_o(error)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    // ---------------- monitor + AXIL subordinate ----------------
    initial begin
        logic aw_done, w_done, ar_done;
        logic hf, awf, wf, bf, arf, rf, rhf, rdf, exp_err;
        int w_wait, cyc, t_hdr;
        resp_exp_t re;
        w_exp_t we;
        aw_done = 0; w_done = 0; ar_done = 0; w_wait = 0; cyc = 0; t_hdr = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                aw_q.delete(); ar_q.delete(); w_q.delete(); resp_q.delete(); rd_q.delete();
                aw_done = 0; w_done = 0; ar_done = 0; w_wait = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                continue;
            end
            cyc++;
            awready = 1;
            wready  = (w_wait >= w_stall_cfg);
            bvalid  = aw_done && w_done;
            bresp   = b_resp_cfg;
            arready = 1;
            rvalid  = ar_done;
            rdata   = r_data_cfg;
            rresp   = r_resp_cfg;
            #1;
            hf  = cmd_hdr_v && hdr_ready;
            awf = awvalid && awready;
            wf  = wvalid && wready;
            bf  = bvalid && bready;
            arf = arvalid && arready;
            rf  = rvalid && rready;
            rhf = resp_hdr_v && resp_rdy;
            rdf = resp_data_v && resp_data_rdy;

            if (hf) begin
                t_hdr = cyc;
                chk("data_rdy_with_hdr", data_ready, 0);
            end
            if (awf) begin
                if (aw_q.size() == 0) flag("aw_unexpected");
                else chk("awaddr", awaddr, aw_q.pop_front());
                chk("awprot", awprot, 0);
            end
            if (wf) begin
                if (w_q.size() == 0) flag("w_unexpected");
                else begin
                    we = w_q.pop_front();
                    chk("wdata", wdata, we.data);
                    chk("wstrb", wstrb, we.strb);
                end
            end
            if (arf) begin
                if (ar_q.size() == 0) flag("ar_unexpected");
                else chk("araddr", araddr, ar_q.pop_front());
                chk("arprot", arprot, 0);
            end
            if (rhf) begin
                if (resp_q.size() == 0) flag("resp_hdr_unexpected");
                else begin
                    re = resp_q.pop_front();
                    chk("resp_hdr", resp_hdr, re.hdr);
                    chk("resp_has_data", resp_has_data, re.has_data);
                    if (re.lat >= 0) chk("resp_latency", cyc - t_hdr, re.lat);
                end
            end
            if (rdf) begin
                if (rd_q.size() == 0) flag("resp_data_unexpected");
                else chk("resp_data", resp_data, rd_q.pop_front());
                chk("resp_last", resp_last, 1);
            end
            exp_err = (bf && bresp != 0) || (rf && rresp != 0);
            if (exp_err || error) chk("error_pulse", error, exp_err);
            if (aw_done && wvalid) begin
                chk("awvalid_after_hs", awvalid, 0);
                chk("bready_before_w", bready, 0);
            end
            if (w_wait > 0) chk("wvalid_held", wvalid, 1);
            if (resp_hdr_v && !resp_rdy) chk("hdr_rdy_blocked", hdr_ready, 0);

            if (wf) w_wait = 0; else if (wvalid) w_wait++;
            aw_done = aw_done || awf;
            w_done  = w_done || wf;
            if (bf) begin aw_done = 0; w_done = 0; end
            ar_done = ar_done || arf;
            if (rf) ar_done = 0;
        end
    end

    // ---------------- stimulus ----------------
    function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t, input logic [2:0] sz,
                                                      input logic [39:0] a, input logic [15:0] p);
        bp_bedrock_mem_header_s h;
        h.msg_type = t; h.size = sz; h.addr = a; h.payload = p;
        return h;
    endfunction

    task automatic send_cmd(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic wr);
        int n;
        @(posedge clk); #1;
        cmd_hdr = h; cmd_hdr_v = 1; cmd_has_data = wr;
        if (wr) begin cmd_data = d; cmd_data_v = 1; cmd_last = 1; end
        n = 0;
        @(negedge clk);
        while (!hdr_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) flag("cmd_hdr_timeout");
        @(posedge clk); #1;
        cmd_hdr_v = 0;
        if (wr) begin
            n = 0;
            @(negedge clk);
            while (!data_ready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) flag("cmd_data_timeout");
            @(posedge clk); #1;
            cmd_data_v = 0; cmd_last = 0;
        end
    endtask

    task automatic do_write(input bp_bedrock_mem_type_e t, input logic [2:0] sz, input logic [39:0] a,
                            input logic [63:0] d, input logic [31:0] exp_aw, input logic [31:0] exp_wd,
                            input logic [3:0] exp_strb, input int lat);
        bp_bedrock_mem_header_s h;
        h = mk_hdr(t, sz, a, 16'(a[15:0] ^ 16'h5A5A));
        aw_q.push_back(exp_aw);
        w_q.push_back('{exp_wd, exp_strb});
        resp_q.push_back('{h, 1'b0, lat});
        send_cmd(h, d, 1'b1);
    endtask

    task automatic do_read(input bp_bedrock_mem_type_e t, input logic [2:0] sz, input logic [39:0] a,
                           input logic [31:0] exp_ar, input logic [63:0] exp_rd, input int lat);
        bp_bedrock_mem_header_s h;
        h = mk_hdr(t, sz, a, 16'(a[15:0] ^ 16'hA5A5));
        ar_q.push_back(exp_ar);
        resp_q.push_back('{h, 1'b1, lat});
        rd_q.push_back(exp_rd);
        send_cmd(h, 64'h0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((aw_q.size() + w_q.size() + ar_q.size() + resp_q.size() + rd_q.size()) != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        if (n >= 300) flag(name);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {hdr_ready, data_ready, awvalid, wvalid, bready, arvalid, rready,
                              resp_hdr_v, resp_data_v, error}, 0);
        @(negedge clk); #2 reset_n = 1;
        @(posedge clk); #1;
        chk("hdr_ready_after_reset", hdr_ready, 1);

        do_write(e_bedrock_mem_uc_wr, 3'd2, 40'h1004, 64'h0000_0000_DEAD_BEEF, 32'h1004, 32'hDEAD_BEEF, 4'hF, 4);
        wait_idle("t1_write_word");
        do_write(e_bedrock_mem_uc_wr, 3'd0, 40'h1003, 64'h1122_3344_5566_775A, 32'h1000, 32'h5A5A_5A5A, 4'h8, 4);
        wait_idle("t2_write_byte");
        r_data_cfg = 32'hBEEF_1234;
        do_read(e_bedrock_mem_uc_rd, 3'd1, 40'h2002, 32'h2000, 64'hBEEF_BEEF_BEEF_BEEF, 3);
        wait_idle("t3_read_half");

        w_stall_cfg = 5;
        do_write(e_bedrock_mem_wr, 3'd2, 40'h3008, 64'h0BAD_F00D, 32'h3008, 32'h0BAD_F00D, 4'hF, -1);
        wait_idle("t4_w_stall");
        w_stall_cfg = 0;

        r_resp_cfg = 2'b10; r_data_cfg = 32'h1122_3344;
        do_read(e_bedrock_mem_uc_rd, 3'd0, 40'h4001, 32'h4000, 64'h3333_3333_3333_3333, 3);
        wait_idle("t5_read_slverr");
        r_resp_cfg = 2'b00;

        resp_rdy = 0; r_data_cfg = 32'hCAFE_F00D;
        do_read(e_bedrock_mem_rd, 3'd2, 40'h5000, 32'h5000, 64'hCAFE_F00D_CAFE_F00D, -1);
        n = 0;
        while (!resp_hdr_v && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) flag("t6_resp_hdr_timeout");
        repeat (10) @(posedge clk);
        #1 resp_rdy = 1;
        wait_idle("t6_resp_backpressure");

        b_resp_cfg = 2'b11;
        do_write(e_bedrock_mem_uc_wr, 3'd0, 40'h6002, 64'h77, 32'h6000, 32'h7777_7777, 4'h4, 4);
        wait_idle("t7_write_decerr");
        b_resp_cfg = 2'b00;

        // Abort a write stuck on W: AW goes out, then reset lands mid-transaction.
        w_stall_cfg = 1000;
        aw_q.push_back(32'h8000);
        send_cmd(mk_hdr(e_bedrock_mem_uc_wr, 3'd2, 40'h8000, 16'h1111), 64'h1234_5678, 1'b1);
        @(posedge clk); #1;
        chk("wvalid_before_reset", wvalid, 1);
        #2 reset_n = 0;
        #1;
        chk("reset_mid_write", {hdr_ready, data_ready, awvalid, wvalid, bready, arvalid, rready,
                                resp_hdr_v, resp_data_v, error}, 0);
        repeat (2) @(negedge clk);
        w_stall_cfg = 0;
        @(negedge clk); #2 reset_n = 1;
        @(posedge clk); #1;
        chk("hdr_ready_after_abort", hdr_ready, 1);

        r_data_cfg = 32'h89AB_CDEF;
        do_read(e_bedrock_mem_uc_rd, 3'd2, 40'h7004, 32'h7004, 64'h89AB_CDEF_89AB_CDEF, 3);
        wait_idle("t9_read_after_reset");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
